copro_result_buffer: RTL and testbench
======================================

# copro_result_buffer

Result-side stage of the CV-X-IF example coprocessor. Sits directly downstream of the coprocessor ALU and buffers its fire-and-forget result stream (no backpressure) in a small FIFO. Presents results to the core on a valid/ready result handshake. Raises an issue-stall signal early enough that no in-flight ALU result is ever dropped.

## Interface
- `XLEN`, 32, result data width.
- `Depth`, 4, number of FIFO entries; power of two, ≥ 2.
- `hartid_t`, logic, hart identifier type.
- `id_t`, logic, instruction identifier type.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock, asynchronous active-low.
- `alu_valid_i` in 1: ALU result valid (push request).
- `alu_result_i` in XLEN: ALU result data.
- `alu_hartid_i` in hartid_t: hart id.
- `alu_id_i` in id_t: instruction id.
- `alu_rd_i` in 5: destination register.
- `alu_we_i` in 1: register write enable.
- `result_valid_o` out 1: head entry valid toward core.
- `result_ready_i` in 1: core accepts head entry.
- `result_data_o` out XLEN: head data.
- `result_hartid_o` out hartid_t: head hart id.
- `result_id_o` out id_t: head id.
- `result_rd_o` out 5: head rd.
- `result_we_o` out 1: head we.
- `issue_stall_o` out 1: upstream must not issue a new instruction to the ALU.
- `count_o` out $clog2(Depth)+1: current occupancy.
- `overflow_o` out 1: one-cycle pulse, push dropped.

## Operation
- Push = `alu_valid_i`; pop = `result_valid_o && result_ready_i`.
- The entry holds {result, hartid, id, rd, we}. It is written at the write pointer. Head is read at the read pointer.
- Pointers are $clog2(Depth) bits and wrap naturally from Depth-1 to 0. Count is tracked separately.
- Simultaneous push and pop when non-empty: both happen, count unchanged.
- Push when full and no pop: the entry is dropped, `overflow_o`=1 for that cycle, and the state is unchanged.
- Push when full with pop in the same cycle: both happen; this is not an overflow.
- Pop when empty is impossible, because `result_valid_o`=0.
- `issue_stall_o` = (count ≥ Depth-1). This reserves one slot for the result of an instruction already inside the 1-cycle ALU.
- Outputs `result_*_o` reflect the head entry.
- When empty, `result_*_o` are driven to '0, except when bypass is compiled in (see Configuration).
- Ordering is strict FIFO. There is no reordering by id or hartid.

## Timing
- Reset values:
  - `result_valid_o`=0, `issue_stall_o`=0, `overflow_o`=0, `count_o`=0.
  - All `result_*_o`=0.
  - Pointers are 0.
  - Storage contents are don't-care but are cleared to 0.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronous), and any in-flight ALU result is lost.
- Latency without bypass: push in cycle N → `result_valid_o`=1 in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- `result_valid_o`, once high, stays high with stable payload until popped.
- `count_o` and `issue_stall_o` update the cycle after a push or pop. `issue_stall_o` is registered-derived, with no combinational path from `alu_valid_i`.
- `overflow_o` is combinational from `alu_valid_i`, full, and pop.

## Configuration
- Macro: `COPRO_RESULT_BYPASS_EN`.
- Defined: when the FIFO is empty and `alu_valid_i`=1:
  - `result_valid_o`=1 and `result_*_o` = the `alu_*_i` inputs in the same cycle (zero latency).
  - If `result_ready_i`=1 in that cycle, the entry is not written and count stays 0.
  - Otherwise the entry is written normally.
- Undefined: there is no combinational path from `alu_*_i` to `result_*_o`, and latency is always 1 cycle.

## Structure
- `cvxif_instr_pkg` gains `localparam int unsigned CoproResultDepth = 4`, used as the top-level default for `Depth`.
- The entry struct depends on `XLEN`, `hartid_t` and `id_t`, so it is a local typedef in the module.
- One sub-module: `copro_result_fifo`, the generic storage (pointers, count, full/empty).
- `copro_result_buffer` adds the stall logic, the overflow pulse and the bypass.

## Test plan
- **Single result, no bypass:** push {result=0x5, id=3, rd=7, we=1} with ready=1 → `result_valid_o`=1 next cycle with the same fields, and count returns to 0 one cycle after the pop.
- **Fill under backpressure:** ready=0, push 4 results 0x10..0x13 on consecutive cycles →
  - `issue_stall_o`=1 from the cycle after the 3rd push.
  - count=4.
  - Raise ready → pops 0x10, 0x11, 0x12, 0x13 in order.
- **Overflow:** full, ready=0, push 0xAA → `overflow_o`=1 for one cycle, count stays 4, and 0xAA never appears at the output.
- **Full with simultaneous push/pop:** full, ready=1, push 0xBB → no overflow, count stays 4, and 0xBB is popped 4th.
- **Wrap-around:** run 10 push/pop pairs with ready toggling pseudo-randomly → the output sequence equals the input sequence and the pointers pass index 3→0 at least twice.
- **Reset mid-stream:** with 2 entries queued, assert `rst_ni`=0 → `result_valid_o`=0 and count=0 immediately. The first push after release is the first output.
- **Bypass (`COPRO_RESULT_BYPASS_EN`):** empty, ready=1, push 0x77 → `result_valid_o`=1 with data=0x77 in the same cycle, and count stays 0.

Source files
------------

// File: rtl/cvxif_instr_pkg.sv
// cvxif_instr_pkg: shared constants for the CV-X-IF example coprocessor.
// The result buffer takes its default FIFO depth from here.
package cvxif_instr_pkg;

  // Default number of entries in the coprocessor result buffer
  localparam int unsigned CoproResultDepth = 4;

  // Width of an integer register address (rd)
  localparam int unsigned RegAddrWidth = 5;

  // Occupancy counter width for a FIFO of the given depth: must represent 0..depth
  function automatic int unsigned copro_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/copro_result_fifo.sv
// copro_result_fifo: generic flat-vector FIFO used by the coprocessor result
// buffer. Keeps separate read/write pointers that wrap naturally (Depth is a
// power of two) plus an explicit occupancy count for full/empty.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored and the caller is expected to flag it.
module copro_result_fifo
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = CoproResultDepth,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = copro_cnt_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    data_o,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [Width-1:0]    mem_reg [Depth];
  logic [PtrWidth-1:0] wr_ptr_reg;
  logic [PtrWidth-1:0] wr_ptr_next;
  logic [PtrWidth-1:0] rd_ptr_reg;
  logic [PtrWidth-1:0] rd_ptr_next;
  logic [CntWidth-1:0] count_reg;
  logic [CntWidth-1:0] count_next;
  logic                push_ok;
  logic                pop_ok;

  assign full_o  = (count_reg == CntWidth'(Depth));
  assign empty_o = (count_reg == '0);

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping for the next cycle
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PtrWidth'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + PtrWidth'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CntWidth'(1);
      2'b01:   count_next = count_reg - CntWidth'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; reset discards every entry at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage: written at the write pointer, cleared on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push_ok) begin
      mem_reg[wr_ptr_reg] <= data_i;
    end
  end

  // Head entry is always visible; the top masks it when the FIFO is empty
  assign data_o  = mem_reg[rd_ptr_reg];
  assign count_o = count_reg;

endmodule

// File: rtl/copro_result_buffer.sv
// copro_result_buffer: result-side stage of the CV-X-IF example coprocessor.
// Buffers the ALU's fire-and-forget result stream and presents it to the core
// on a valid/ready handshake. issue_stall_o is raised one slot early so a
// result already inside the single-cycle ALU always finds room.
// Optional feature: define COPRO_RESULT_BYPASS_EN to let a result arriving at
// an empty buffer appear on result_*_o in the same cycle.
module copro_result_buffer
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned Depth = CoproResultDepth,
  parameter type hartid_t      = logic,
  parameter type id_t          = logic
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // ALU result stream (no backpressure)
  input  logic                      alu_valid_i,
  input  logic [XLEN-1:0]           alu_result_i,
  input  hartid_t                   alu_hartid_i,
  input  id_t                       alu_id_i,
  input  logic [RegAddrWidth-1:0]   alu_rd_i,
  input  logic                      alu_we_i,
  // Result interface toward the core
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [XLEN-1:0]           result_data_o,
  output hartid_t                   result_hartid_o,
  output id_t                       result_id_o,
  output logic [RegAddrWidth-1:0]   result_rd_o,
  output logic                      result_we_o,
  // Status
  output logic                      issue_stall_o,
  output logic [$clog2(Depth):0]    count_o,
  output logic                      overflow_o
);

  localparam int unsigned CntWidth = copro_cnt_width(Depth);

  typedef struct packed {
    logic [XLEN-1:0]         data;
    hartid_t                 hartid;
    id_t                     id;
    logic [RegAddrWidth-1:0] rd;
    logic                    we;
  } entry_t;

  localparam int unsigned EntryWidth = $bits(entry_t);

  entry_t                  alu_entry;
  entry_t                  head_entry;
  entry_t                  out_entry;
  logic [EntryWidth-1:0]   head_raw;
  logic [CntWidth-1:0]     fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    pop_fire;
  logic                    bypass_active;

  // Pack the incoming ALU fields into one storage word
  always_comb begin
    alu_entry        = '0;
    alu_entry.data   = alu_result_i;
    alu_entry.hartid = alu_hartid_i;
    alu_entry.id     = alu_id_i;
    alu_entry.rd     = alu_rd_i;
    alu_entry.we     = alu_we_i;
  end

  assign head_entry = entry_t'(head_raw);

`ifdef COPRO_RESULT_BYPASS_EN
  // An empty buffer forwards the arriving result straight to the core
  assign bypass_active = fifo_empty && alu_valid_i;
`else
  // Results always spend at least one cycle in storage
  assign bypass_active = 1'b0;
`endif

  assign result_valid_o = !fifo_empty || bypass_active;
  assign pop_fire       = result_valid_o && result_ready_i;

  // Only stored entries are popped from storage; a bypassed result consumed
  // in the same cycle is never written
  assign fifo_pop  = pop_fire && !fifo_empty;
  assign fifo_push = alu_valid_i && !(bypass_active && result_ready_i);

  // A result arriving at a full buffer with nothing leaving is lost
  assign overflow_o = alu_valid_i && fifo_full && !pop_fire;

  // Stall from the registered occupancy only: keep one slot for the ALU
  assign issue_stall_o = (fifo_count >= CntWidth'(Depth - 1));
  assign count_o       = fifo_count;

  // Select what the core sees: stored head, bypassed input, or zeros
  always_comb begin
    out_entry = '0;
    if (!fifo_empty) begin
      out_entry = head_entry;
    end else if (bypass_active) begin
      out_entry = alu_entry;
    end
  end

  assign result_data_o   = out_entry.data;
  assign result_hartid_o = out_entry.hartid;
  assign result_id_o     = out_entry.id;
  assign result_rd_o     = out_entry.rd;
  assign result_we_o     = out_entry.we;

  copro_result_fifo #(
    .Width (EntryWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (alu_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_raw),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_copro_result_buffer.sv
// Testbench for copro_result_buffer: scenario tasks with inline checks against
// a queue-based reference model of the result FIFO.
module tb_copro_result_buffer;

  localparam int Depth = 4;

  typedef logic [1:0] hart_t;
  typedef logic [3:0] iid_t;

  typedef struct packed {
    logic [31:0] data;
    hart_t       hartid;
    iid_t        id;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  hart_t       alu_hartid_i = '0;
  iid_t        alu_id_i = '0;
  logic [4:0]  alu_rd_i = '0;
  logic        alu_we_i = 1'b0;
  logic        result_ready_i = 1'b0;
  logic        result_valid_o;
  logic [31:0] result_data_o;
  hart_t       result_hartid_o;
  iid_t        result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic        issue_stall_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;

  ent_t q[$];
  ent_t obs;

  always #5 clk_i = ~clk_i;

  copro_result_buffer #(
    .XLEN     (32),
    .Depth    (Depth),
    .hartid_t (hart_t),
    .id_t     (iid_t)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .alu_valid_i     (alu_valid_i),
    .alu_result_i    (alu_result_i),
    .alu_hartid_i    (alu_hartid_i),
    .alu_id_i        (alu_id_i),
    .alu_rd_i        (alu_rd_i),
    .alu_we_i        (alu_we_i),
    .result_valid_o  (result_valid_o),
    .result_ready_i  (result_ready_i),
    .result_data_o   (result_data_o),
    .result_hartid_o (result_hartid_o),
    .result_id_o     (result_id_o),
    .result_rd_o     (result_rd_o),
    .result_we_o     (result_we_o),
    .issue_stall_o   (issue_stall_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  assign obs = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};

  // ---------------- reference model ----------------
  function automatic ent_t cur_in();
    return {alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i};
  endfunction

  function automatic bit m_bypass();
`ifdef COPRO_RESULT_BYPASS_EN
    return alu_valid_i && (q.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_valid();
    return (q.size() != 0) || m_bypass();
  endfunction

  function automatic ent_t m_head();
    if (q.size() != 0) return q[0];
    if (m_bypass()) return cur_in();
    return '0;
  endfunction

  function automatic bit m_ovf();
    return alu_valid_i && (q.size() == Depth) && !result_ready_i;
  endfunction

  function automatic ent_t rand_ent(input logic [31:0] d);
    ent_t e;
    e.data   = d;
    e.hartid = hart_t'($urandom);
    e.id     = iid_t'($urandom);
    e.rd     = 5'($urandom);
    e.we     = 1'($urandom);
    return e;
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later
  task automatic drive(input bit v, input ent_t e, input bit rdy);
    @(negedge clk_i);
    alu_valid_i    = v;
    alu_result_i   = e.data;
    alu_hartid_i   = e.hartid;
    alu_id_i       = e.id;
    alu_rd_i       = e.rd;
    alu_we_i       = e.we;
    result_ready_i = rdy;
    #1;
  endtask

  // Advance the model across the rising edge using the applied inputs
  task automatic commit();
    bit pop;
    bit full;
    bit byp_take;
    ent_t e;
    @(posedge clk_i);
    e        = cur_in();
    pop      = m_valid() && result_ready_i;
    byp_take = m_bypass() && result_ready_i;
    full     = (q.size() == Depth);
    if (pop && q.size() != 0) void'(q.pop_front());
    if (alu_valid_i && !byp_take && !(full && !pop)) q.push_back(e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", result_valid_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++; if (issue_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", issue_stall_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", obs); end
    $display("reset: valid=%0b count=%0d stall=%0b", result_valid_o, count_o, issue_stall_o);
    q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    ent_t e;
    e.data = 32'h5; e.hartid = 2'd1; e.id = 4'd3; e.rd = 5'd7; e.we = 1'b1;
    drive(1'b1, e, 1'b1);
    checks++; if (result_valid_o !== m_valid()) begin errors++; $display("FAIL single_push_valid: got %0b want %0b", result_valid_o, m_valid()); end
    commit();
    drive(1'b0, rand_ent(32'h0), 1'b1);
`ifndef COPRO_RESULT_BYPASS_EN
    checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid_next: got %0b want 1", result_valid_o); end
    checks++; if (obs !== e) begin errors++; $display("FAIL single_payload: got %h want %h", obs, e); end
`endif
    checks++; if (count_o !== 3'(q.size())) begin errors++; $display("FAIL single_count_mid: got %0d want %0d", count_o, q.size()); end
    commit();
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL single_count_after: got %0d want 0", count_o); end
    $display("single: data=%h count=%0d", e.data, count_o);
    commit();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rand_ent(32'h10 + 32'(i)), 1'b0);
      checks++; if (issue_stall_o !== (i >= 3)) begin errors++; $display("FAIL fill_stall_%0d: got %0b want %0b", i, issue_stall_o, (i >= 3)); end
      commit();
    end
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count_o); end
    checks++; if (issue_stall_o !== 1'b1) begin errors++; $display("FAIL fill_stall_full: got %0b want 1", issue_stall_o); end
    $display("fill: count=%0d stall=%0b", count_o, issue_stall_o);
    commit();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, rand_ent(32'h0), 1'b1);
      checks++; if (result_valid_o !== 1'b1 || result_data_o !== 32'h10 + 32'(i)) begin
        errors++; $display("FAIL fill_drain_%0d: got valid=%0b data=%h want valid=1 data=%h", i, result_valid_o, result_data_o, 32'h10 + 32'(i));
      end
      checks++; if (obs !== m_head()) begin errors++; $display("FAIL fill_drain_payload_%0d: got %h want %h", i, obs, m_head()); end
      $display("fill pop: data=%h", result_data_o);
      commit();
    end
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (count_o !== 3'd0 || result_valid_o !== 1'b0) begin errors++; $display("FAIL fill_empty: got count=%0d valid=%0b want 0/0", count_o, result_valid_o); end
    commit();
  endtask

  task automatic test_overflow_and_full_pushpop();
    logic [31:0] exp_seq [4];
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rand_ent(32'h20 + 32'(i)), 1'b0);
      commit();
    end
    drive(1'b1, rand_ent(32'hAA), 1'b0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b want 1", overflow_o); end
    $display("overflow: push=aa ovf=%0b count=%0d", overflow_o, count_o);
    commit();
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow_o); end
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count_o); end
    commit();
    // Full with a pop in the same cycle: the push is taken, not dropped
    drive(1'b1, rand_ent(32'hBB), 1'b1);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fullpp_ovf: got %0b want 0", overflow_o); end
    checks++; if (result_data_o !== 32'h20) begin errors++; $display("FAIL fullpp_head: got %h want 20", result_data_o); end
    commit();
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fullpp_count: got %0d want 4", count_o); end
    commit();
    exp_seq[0] = 32'h21; exp_seq[1] = 32'h22; exp_seq[2] = 32'h23; exp_seq[3] = 32'hBB;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, rand_ent(32'h0), 1'b1);
      checks++; if (result_valid_o !== 1'b1 || result_data_o !== exp_seq[i] || result_data_o === 32'hAA) begin
        errors++; $display("FAIL fullpp_drain_%0d: got valid=%0b data=%h want valid=1 data=%h", i, result_valid_o, result_data_o, exp_seq[i]);
      end
      $display("fullpp pop: data=%h", result_data_o);
      commit();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] sent[$];
    logic [31:0] got[$];
    int pushes = 0;
    int cyc = 0;
    bit v;
    bit rdy;
    ent_t e;
    while ((pushes < 10 || q.size() != 0) && cyc < 300) begin
      v   = (pushes < 10) && (q.size() < Depth) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      e   = rand_ent($urandom);
      drive(v, e, rdy);
      checks++; if (result_valid_o !== m_valid()) begin errors++; $display("FAIL wrap_valid_c%0d: got %0b want %0b", cyc, result_valid_o, m_valid()); end
      checks++; if (m_valid() && obs !== m_head()) begin errors++; $display("FAIL wrap_payload_c%0d: got %h want %h", cyc, obs, m_head()); end
      checks++; if (count_o !== 3'(q.size())) begin errors++; $display("FAIL wrap_count_c%0d: got %0d want %0d", cyc, count_o, q.size()); end
      checks++; if (issue_stall_o !== (q.size() >= Depth - 1)) begin errors++; $display("FAIL wrap_stall_c%0d: got %0b want %0b", cyc, issue_stall_o, (q.size() >= Depth - 1)); end
      checks++; if (overflow_o !== m_ovf()) begin errors++; $display("FAIL wrap_ovf_c%0d: got %0b want %0b", cyc, overflow_o, m_ovf()); end
      if (result_valid_o && rdy) got.push_back(result_data_o);
      if (v) begin sent.push_back(e.data); pushes++; end
      $display("wrap c%0d: push=%0b data=%h ready=%0b out_valid=%0b out=%h count=%0d", cyc, v, e.data, rdy, result_valid_o, result_data_o, count_o);
      commit();
      cyc++;
    end
    checks++; if (cyc >= 300) begin errors++; $display("FAIL wrap_timeout: got %0d cycles want < 300", cyc); end
    checks++; if (got.size() != sent.size()) begin errors++; $display("FAIL wrap_len: got %0d want %0d", got.size(), sent.size()); end
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL wrap_order_%0d: got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, rand_ent(32'h31), 1'b0); commit();
    drive(1'b1, rand_ent(32'h32), 1'b0); commit();
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 2", count_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", result_valid_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", count_o); end
    $display("reset mid: valid=%0b count=%0d", result_valid_o, count_o);
    q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, rand_ent(32'h41), 1'b1);
`ifdef COPRO_RESULT_BYPASS_EN
    checks++; if (result_valid_o !== 1'b1 || result_data_o !== 32'h41) begin errors++; $display("FAIL rstmid_first: got valid=%0b data=%h want 1/41", result_valid_o, result_data_o); end
    commit();
`else
    commit();
    drive(1'b0, rand_ent(32'h0), 1'b1);
    checks++; if (result_valid_o !== 1'b1 || result_data_o !== 32'h41) begin errors++; $display("FAIL rstmid_first: got valid=%0b data=%h want 1/41", result_valid_o, result_data_o); end
    commit();
`endif
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rstmid_post_count: got %0d want 0", count_o); end
    commit();
  endtask

`ifdef COPRO_RESULT_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, rand_ent(32'h77), 1'b1);
    checks++; if (result_valid_o !== 1'b1 || result_data_o !== 32'h77) begin errors++; $display("FAIL bypass_same_cycle: got valid=%0b data=%h want 1/77", result_valid_o, result_data_o); end
    $display("bypass: valid=%0b data=%h", result_valid_o, result_data_o);
    commit();
    drive(1'b0, rand_ent(32'h0), 1'b0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d want 0", count_o); end
    commit();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_overflow_and_full_pushpop();
    test_wrap();
    test_reset_mid();
`ifdef COPRO_RESULT_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timeout");
  end

endmodule
